// File: rtl/riscvboy_dbus_decoder_if.sv
// riscvboy_dbus_decoder_if: core-side and slave-side bus signals of the data-bus decoder
//   master : drives the core request (i_mem_*) and the slave responses (i_slv_*)
//   slave  : the decoder; drives the core response (o_mem_*) and slave strobes (o_slv_*)
interface riscvboy_dbus_decoder_if #(
    parameter int N_SLV  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                    i_mem_ren;
    logic                    i_mem_wen;
    logic [DATA_W/8-1:0]     i_mem_wbe;
    logic [ADDR_W-1:0]       i_mem_addr;
    logic [DATA_W-1:0]       i_mem_wdata;
    logic [DATA_W-1:0]       o_mem_rdata;
    logic                    o_mem_ack;
    logic                    o_mem_err;
    logic                    o_mem_busy;
    logic [N_SLV-1:0]        o_slv_sel;
    logic                    o_slv_wen;
    logic [DATA_W/8-1:0]     o_slv_wbe;
    logic [ADDR_W-1:0]       o_slv_addr;
    logic [DATA_W-1:0]       o_slv_wdata;
    logic [N_SLV-1:0]        i_slv_ack;
    logic [N_SLV*DATA_W-1:0] i_slv_rdata;

    modport master (
        output i_mem_ren, i_mem_wen, i_mem_wbe, i_mem_addr, i_mem_wdata, i_slv_ack, i_slv_rdata,
        input  o_mem_rdata, o_mem_ack, o_mem_err, o_mem_busy,
        input  o_slv_sel, o_slv_wen, o_slv_wbe, o_slv_addr, o_slv_wdata
    );

    modport slave (
        input  i_mem_ren, i_mem_wen, i_mem_wbe, i_mem_addr, i_mem_wdata, i_slv_ack, i_slv_rdata,
        output o_mem_rdata, o_mem_ack, o_mem_err, o_mem_busy,
        output o_slv_sel, o_slv_wen, o_slv_wbe, o_slv_addr, o_slv_wdata
    );
endinterface

// File: rtl/riscvboy_dbus_decoder.sv
// riscvboy_dbus_decoder: address-mapped data-bus decoder, one outstanding access, ack/err/timeout
//   clk_sys : system clock
//   rst     : synchronous active-high reset
//   bus     : core request/response and per-slave strobe/ack/rdata (slave modport)
module riscvboy_dbus_decoder #(
    parameter int                      N_SLV    = 4,
    parameter int                      ADDR_W   = 32,
    parameter int                      DATA_W   = 32,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = {4{32'hF000_0000}},
    parameter int                      TIMEOUT  = 15
) (
    input logic clk_sys,
    input logic rst,
    riscvboy_dbus_decoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t            state;
    logic [N_SLV-1:0]  hit;
    logic [N_SLV-1:0]  cur;
    logic [7:0]        cnt;
    logic [DATA_W-1:0] sel_rdata;
    logic              req;
    logic              ack_hit;

    // descending scan so the lowest matching index wins on overlap
    always_comb begin
        hit = '0;
        for (int i = N_SLV - 1; i >= 0; i--)
            if ((bus.i_mem_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit    = '0;
                hit[i] = 1'b1;
            end
        sel_rdata = '0;
        for (int i = 0; i < N_SLV; i++)
            if (cur[i]) sel_rdata = bus.i_slv_rdata[i*DATA_W +: DATA_W];
    end

    assign req     = bus.i_mem_ren | bus.i_mem_wen;
    assign ack_hit = |(bus.i_slv_ack & cur);

    // RESP and IDLE both accept a new request, so the ack cycle can start the next access
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state           <= IDLE;
            cur             <= '0;
            cnt             <= '0;
            bus.o_mem_rdata <= '0;
            bus.o_mem_ack   <= 1'b0;
            bus.o_mem_err   <= 1'b0;
            bus.o_mem_busy  <= 1'b0;
            bus.o_slv_sel   <= '0;
            bus.o_slv_wen   <= 1'b0;
            bus.o_slv_wbe   <= '0;
            bus.o_slv_addr  <= '0;
            bus.o_slv_wdata <= '0;
        end else begin
            bus.o_mem_ack <= 1'b0;
            bus.o_mem_err <= 1'b0;
            bus.o_slv_sel <= '0;
            if (state == ACCESS) begin
                if (ack_hit) begin
                    state           <= RESP;
                    bus.o_mem_ack   <= 1'b1;
                    bus.o_mem_rdata <= bus.o_slv_wen ? '0 : sel_rdata;
                end else if (cnt == TO) begin
                    state           <= RESP;
                    bus.o_mem_ack   <= 1'b1;
                    bus.o_mem_err   <= 1'b1;
                    bus.o_mem_rdata <= '0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else if (req) begin
                bus.o_mem_busy <= 1'b1;
                if ((bus.i_mem_ren & bus.i_mem_wen) || hit == '0) begin
                    state           <= IDLE;
                    bus.o_mem_ack   <= 1'b1;
                    bus.o_mem_err   <= 1'b1;
                    bus.o_mem_rdata <= '0;
                end else begin
                    state           <= ACCESS;
                    cur             <= hit;
                    cnt             <= '0;
                    bus.o_slv_sel   <= hit;
                    bus.o_slv_wen   <= bus.i_mem_wen;
                    bus.o_slv_wbe   <= bus.i_mem_wen ? bus.i_mem_wbe : '0;
                    bus.o_slv_addr  <= bus.i_mem_addr;
                    bus.o_slv_wdata <= bus.i_mem_wdata;
                end
            end else begin
                state          <= IDLE;
                bus.o_mem_busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_riscvboy_dbus_decoder.sv
// tb_riscvboy_dbus_decoder: transaction-level model and per-cycle compare for the data-bus decoder
module tb_riscvboy_dbus_decoder;
    localparam int NC = 512;
    localparam int TO = 15;

    logic clk_sys = 1'b0;
    logic rst     = 1'b1;
    int   cyc     = 0;
    int   tests   = 0;
    int   fails   = 0;
    bit   chk_en  = 1'b0;

    riscvboy_dbus_decoder_if #(.N_SLV(4), .ADDR_W(32), .DATA_W(32)) bus ();

    riscvboy_dbus_decoder dut (.clk_sys(clk_sys), .rst(rst), .bus(bus));

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    // expected per-cycle outputs, filled from transaction-level rules
    bit          e_ack[NC], e_err[NC], e_busy[NC], rd_set[NC], sc[NC], e_wen[NC];
    logic [3:0]  e_sel[NC], e_wbe[NC], sack[NC];
    logic [31:0] rd_val[NC], e_addr[NC], e_wdata[NC];
    logic [31:0] srd[4] = '{32'h0A0A_0A0A, 32'hCAFE_F00D, 32'h2222_2222, 32'h3333_3333};
    logic [31:0] m_rd = '0;
    int          resp_cyc = 0;

    task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        bus.i_mem_ren = 1'b0;
        bus.i_mem_wen = 1'b0;
        bus.i_slv_ack = (cyc < NC) ? sack[cyc] : 4'h0;
    endtask

    task automatic run_to(int c);
        while (cyc < c) tick();
        @(negedge clk_sys);
    endtask

    // slave at addr[31:28] when below 4; dly = cycles from strobe to slave ack, 0 = never
    task automatic req(bit r, bit w, logic [31:0] a, logic [3:0] be, logic [31:0] d, int dly);
        int t, idx, rc;
        bit er;
        logic [31:0] rv;
        t = cyc;
        bus.i_mem_ren   = r;
        bus.i_mem_wen   = w;
        bus.i_mem_addr  = a;
        bus.i_mem_wbe   = be;
        bus.i_mem_wdata = d;
        if (t < resp_cyc) return;
        idx = int'(a >> 28);
        if ((r && w) || idx >= 4) begin
            rc = t + 1; er = 1'b1; rv = '0;
        end else begin
            e_sel[t+1] = 4'(1 << idx);
            if (dly >= 1 && dly <= TO) begin
                rc = t + 2 + dly; er = 1'b0; rv = r ? srd[idx] : 32'h0;
            end else begin
                rc = t + TO + 2; er = 1'b1; rv = '0;
            end
            if (dly > 0) sack[t+1+dly][idx] = 1'b1;
            for (int c = t + 1; c < rc; c++) begin
                sc[c] = 1'b1; e_addr[c] = a; e_wen[c] = w; e_wbe[c] = w ? be : 4'h0; e_wdata[c] = d;
            end
        end
        for (int c = t + 1; c <= rc; c++) e_busy[c] = 1'b1;
        e_ack[rc] = 1'b1; e_err[rc] = er; rd_set[rc] = 1'b1; rd_val[rc] = rv;
        resp_cyc = rc;
    endtask

    task automatic stray(int c, int idx);
        sack[c][idx] = 1'b1;
    endtask

    task automatic model_reset(int r);
        for (int c = r + 1; c < NC; c++) begin
            e_ack[c] = 1'b0; e_err[c] = 1'b0; e_busy[c] = 1'b0; e_sel[c] = '0; sc[c] = 1'b0; rd_set[c] = 1'b0;
        end
        rd_set[r+1] = 1'b1; rd_val[r+1] = '0;
        resp_cyc = r + 1;
    endtask

    always @(negedge clk_sys) begin
        if (chk_en && cyc < NC) begin
            if (rd_set[cyc]) m_rd = rd_val[cyc];
            chk("ack", 64'(bus.o_mem_ack), 64'(e_ack[cyc]));
            chk("busy", 64'(bus.o_mem_busy), 64'(e_busy[cyc]));
            chk("sel", 64'(bus.o_slv_sel), 64'(e_sel[cyc]));
            chk("rdata", 64'(bus.o_mem_rdata), 64'(m_rd));
            if (e_ack[cyc]) chk("err", 64'(bus.o_mem_err), 64'(e_err[cyc]));
            if (sc[cyc]) begin
                chk("slv_addr", 64'(bus.o_slv_addr), 64'(e_addr[cyc]));
                chk("slv_wen", 64'(bus.o_slv_wen), 64'(e_wen[cyc]));
                chk("slv_wbe", 64'(bus.o_slv_wbe), 64'(e_wbe[cyc]));
                chk("slv_wdata", 64'(bus.o_slv_wdata), 64'(e_wdata[cyc]));
            end
        end
    end

    initial begin
        int t;
        bus.i_mem_ren   = 1'b0;
        bus.i_mem_wen   = 1'b0;
        bus.i_mem_wbe   = '0;
        bus.i_mem_addr  = '0;
        bus.i_mem_wdata = '0;
        bus.i_slv_ack   = '0;
        bus.i_slv_rdata = {srd[3], srd[2], srd[1], srd[0]};
        repeat (3) @(posedge clk_sys);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk_sys);
        chk("rst_ack", 64'(bus.o_mem_ack), 64'h0);
        chk("rst_busy", 64'(bus.o_mem_busy), 64'h0);
        chk("rst_rdata", 64'(bus.o_mem_rdata), 64'h0);
        // read slave1, ack two cycles after strobe
        tick(); t = cyc;
        req(1, 0, 32'h1000_0010, 4'hF, 32'hDEAD_BEEF, 2);
        run_to(t + 1); chk("t1_sel", 64'(bus.o_slv_sel), 64'h2);
        run_to(t + 4); chk("t1_ack", 64'(bus.o_mem_ack), 64'h1);
        chk("t1_rdata", 64'(bus.o_mem_rdata), 64'hCAFE_F00D);
        // write slave0 issued in the ack cycle, slave acks right after strobe
        t = cyc;
        req(0, 1, 32'h0000_0004, 4'b0011, 32'h1234_5678, 1);
        run_to(t + 1); chk("t2_wen", 64'(bus.o_slv_wen), 64'h1);
        chk("t2_wbe", 64'(bus.o_slv_wbe), 64'h3);
        run_to(t + 3); chk("t2_ack", 64'(bus.o_mem_ack), 64'h1);
        chk("t2_rdata", 64'(bus.o_mem_rdata), 64'h0);
        // unmapped read, next request accepted in its ack cycle
        tick(); tick(); t = cyc;
        req(1, 0, 32'h9000_0000, 4'hF, 32'h0, 0);
        run_to(t + 1); chk("t3_err", 64'(bus.o_mem_err), 64'h1);
        chk("t3_sel", 64'(bus.o_slv_sel), 64'h0);
        t = cyc;
        req(1, 0, 32'h0000_0008, 4'h0, 32'h0, 3);
        run_to(t + 1); chk("t3_next_sel", 64'(bus.o_slv_sel), 64'h1);
        run_to(t + 5);
        // timeout on slave2, foreign and late acks ignored
        tick(); t = cyc;
        req(1, 0, 32'h2000_0000, 4'h0, 32'h0, 0);
        stray(t + 5, 1);
        stray(t + 19, 2);
        run_to(t + 17); chk("t4_ack", 64'(bus.o_mem_ack), 64'h1);
        chk("t4_err", 64'(bus.o_mem_err), 64'h1);
        run_to(t + 20); chk("t4_late", 64'(bus.o_mem_ack), 64'h0);
        // ack exactly at the timeout count wins; one later loses
        tick(); t = cyc;
        req(1, 0, 32'h3000_0000, 4'h0, 32'h0, 15);
        run_to(t + 17); chk("t5_err", 64'(bus.o_mem_err), 64'h0);
        chk("t5_rdata", 64'(bus.o_mem_rdata), 64'h3333_3333);
        t = cyc;
        req(1, 0, 32'h3000_0000, 4'h0, 32'h0, 16);
        run_to(t + 17); chk("t5b_err", 64'(bus.o_mem_err), 64'h1);
        // ren and wen together
        tick(); t = cyc;
        req(1, 1, 32'h2000_0000, 4'hF, 32'h0, 1);
        run_to(t + 1); chk("t6_err", 64'(bus.o_mem_err), 64'h1);
        chk("t6_sel", 64'(bus.o_slv_sel), 64'h0);
        // request during an access is ignored
        tick(); t = cyc;
        req(1, 0, 32'h1000_0000, 4'h0, 32'h0, 4);
        run_to(t + 2);
        req(1, 0, 32'h2000_0000, 4'h0, 32'h0, 1);
        run_to(t + 3); chk("t7_sel", 64'(bus.o_slv_sel), 64'h0);
        run_to(t + 6); chk("t7_ack", 64'(bus.o_mem_ack), 64'h1);
        // reset mid-access
        tick(); t = cyc;
        req(1, 0, 32'h3000_0000, 4'h0, 32'h0, 5);
        run_to(t + 2);
        rst = 1'b1;
        model_reset(t + 2);
        tick();
        rst = 1'b0;
        @(negedge clk_sys);
        chk("t8_ack", 64'(bus.o_mem_ack), 64'h0);
        chk("t8_busy", 64'(bus.o_mem_busy), 64'h0);
        chk("t8_addr", 64'(bus.o_slv_addr), 64'h0);
        chk("t8_rdata", 64'(bus.o_mem_rdata), 64'h0);
        run_to(t + 8);
        t = cyc;
        req(1, 0, 32'h1000_0004, 4'h0, 32'h0, 1);
        run_to(t + 3); chk("t8_next_ack", 64'(bus.o_mem_ack), 64'h1);
        chk("t8_next_rdata", 64'(bus.o_mem_rdata), 64'hCAFE_F00D);
        repeat (3) tick();
        @(negedge clk_sys);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
